xgmac_pause_ctrl: RTL and testbench

//   Generates 802.3x PAUSE requests (pause_req/pause_val) for the 10G MAC TX path from
//   the RX buffer fill level. XOFF/XON hysteresis, periodic XOFF refresh, min request gap.

---
 rtl/xgmac_pkg.sv | 18 +
 rtl/xgmac_sat_cnt16.sv | 20 ++
 rtl/xgmac_pause_ctrl.sv | 122 ++++++++++++
 tb/tb_xgmac_pause_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmac_pkg.sv
// Purpose : shared constants and types for the 10G MAC pause/flow-control logic.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package xgmac_pkg;

  // pause_val carried by an XON (release) request: zero quanta
  localparam logic [15:0] PAUSE_XON_VAL = 16'h0000;

  // One pause quantum is 512 bit times = 8 clocks of a 64-bit datapath at 156.25 MHz
  localparam int unsigned CLK_PER_QUANTUM = 8;

  // What the link partner has last been told
  typedef enum logic {
    ST_XON  = 1'b0,
    ST_XOFF = 1'b1
  } pause_st_e;

endpackage

// File: rtl/xgmac_sat_cnt16.sv
// Purpose : 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
// Latency : count reflects an inc on the clock edge that samples it.
// Backpr. : none; inc is accepted every cycle.
// Ports   : clk, rst_n (async active-low), inc (count one event), cnt (current count).
module xgmac_sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/xgmac_pause_ctrl.sv
// Purpose : 802.3x PAUSE request generator (XOFF/XON hysteresis, XOFF refresh, min pulse gap).
// Latency : 2 clocks from fifo_level to pause_req (level register + decision register).
// Backpr. : none; requests arising inside the min gap are dropped, not queued.
// Ports   : clk, rst_n (async active-low), enable, fifo_level -> pause_req (1-cycle pulse),
//           pause_val (held between pulses), xoff_active, xoff_cnt / xon_cnt (saturating).
module xgmac_pause_ctrl
  import xgmac_pkg::*;
#(
  parameter int unsigned C_LEVEL_W      = 12,
  parameter int unsigned C_XOFF_THRESH  = 3072,
  parameter int unsigned C_XON_THRESH   = 1024,
  parameter logic [15:0] C_PAUSE_QUANTA = 16'hFFFF,
  parameter int unsigned C_TMR_W        = 20,
  parameter int unsigned C_REFRESH_CYC  = 262144,
  parameter int unsigned C_MIN_GAP      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [C_LEVEL_W-1:0] fifo_level,
  output logic                 pause_req,
  output logic [15:0]          pause_val,
  output logic                 xoff_active,
  output logic [15:0]          xoff_cnt,
  output logic [15:0]          xon_cnt
);

  localparam logic [C_LEVEL_W-1:0] XOFF_LVL = C_LEVEL_W'(C_XOFF_THRESH);
  localparam logic [C_LEVEL_W-1:0] XON_LVL  = C_LEVEL_W'(C_XON_THRESH);
  localparam int unsigned          GAP_W    = $clog2(C_MIN_GAP + 1);
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(C_MIN_GAP - 1);
  // Reload with one less than the period: the refresh decision is taken on the edge
  // after the timer reads zero, so pulses land exactly C_REFRESH_CYC clocks apart.
  localparam logic [C_TMR_W-1:0]   TMR_LOAD = C_TMR_W'(C_REFRESH_CYC - 1);

  logic [C_LEVEL_W-1:0] lvl_q;
  logic [GAP_W-1:0]     gap_q;
  logic [C_TMR_W-1:0]   tmr_q;
  pause_st_e            st_q, st_nxt;
  logic                 fire, fire_xoff;
  logic                 want_xoff, gap_zero, tmr_zero;

  assign xoff_active = (st_q == ST_XOFF);
  assign gap_zero    = (gap_q == '0);
  assign tmr_zero    = (tmr_q == '0);

  // Hysteresis: once paused, stay paused until the level drains to the XON mark
  assign want_xoff = enable & ((lvl_q >= XOFF_LVL) | (xoff_active & (lvl_q > XON_LVL)));

  always_comb begin
    st_nxt    = st_q;
    fire      = 1'b0;
    fire_xoff = 1'b0;
    case (st_q)
      ST_XON: begin
        if (want_xoff && gap_zero) begin
          fire      = 1'b1;
          fire_xoff = 1'b1;
          st_nxt    = ST_XOFF;
        end
      end
      ST_XOFF: begin
        // Release wins over a refresh that falls due on the same cycle
        if (!want_xoff && gap_zero) begin
          fire   = 1'b1;
          st_nxt = ST_XON;
        end else if (tmr_zero && gap_zero) begin
          fire      = 1'b1;
          fire_xoff = 1'b1;
        end
      end
      default: st_nxt = ST_XON;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q     <= '0;
      st_q      <= ST_XON;
      gap_q     <= '0;
      tmr_q     <= '0;
      pause_req <= 1'b0;
      pause_val <= PAUSE_XON_VAL;
    end else begin
      lvl_q     <= fifo_level;
      st_q      <= st_nxt;
      pause_req <= fire;
      if (fire) begin
        pause_val <= fire_xoff ? C_PAUSE_QUANTA : PAUSE_XON_VAL;
      end
      if (fire) begin
        gap_q <= GAP_LOAD;
      end else if (!gap_zero) begin
        gap_q <= gap_q - GAP_W'(1);
      end
      if (fire && fire_xoff) begin
        tmr_q <= TMR_LOAD;
      end else if ((st_q == ST_XOFF) && !tmr_zero) begin
        tmr_q <= tmr_q - C_TMR_W'(1);
      end
    end
  end

  logic inc_xoff, inc_xon;
  assign inc_xoff = fire & fire_xoff;
  assign inc_xon  = fire & ~fire_xoff;

  xgmac_sat_cnt16 u_xoff_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_xoff),
    .cnt   (xoff_cnt)
  );

  xgmac_sat_cnt16 u_xon_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_xon),
    .cnt   (xon_cnt)
  );

endmodule

// File: tb/tb_xgmac_pause_ctrl.sv
// Purpose : self-checking bench for xgmac_pause_ctrl; timestamp-based reference model
//           plus directed scenarios and a randomized level/enable phase.
// Latency : n/a.
// Backpr. : n/a.
module tb_xgmac_pause_ctrl;

  localparam int XOFF_T  = 3072;
  localparam int XON_T   = 1024;
  localparam int REFRESH = 200;
  localparam int MIN_GAP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] fifo_level = '0;
  logic        pause_req;
  logic [15:0] pause_val;
  logic        xoff_active;
  logic [15:0] xoff_cnt;
  logic [15:0] xon_cnt;

  // standalone counter for the saturation boundary (65535 pulses would take too long via the top)
  logic        sat_rst_n = 1'b1;
  logic        sat_inc = 1'b0;
  logic [15:0] sat_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  xgmac_pause_ctrl #(
    .C_LEVEL_W      (12),
    .C_XOFF_THRESH  (XOFF_T),
    .C_XON_THRESH   (XON_T),
    .C_PAUSE_QUANTA (16'hFFFF),
    .C_TMR_W        (20),
    .C_REFRESH_CYC  (REFRESH),
    .C_MIN_GAP      (MIN_GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fifo_level  (fifo_level),
    .pause_req   (pause_req),
    .pause_val   (pause_val),
    .xoff_active (xoff_active),
    .xoff_cnt    (xoff_cnt),
    .xon_cnt     (xon_cnt)
  );

  xgmac_sat_cnt16 u_sat (
    .clk   (clk),
    .rst_n (sat_rst_n),
    .inc   (sat_inc),
    .cnt   (sat_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model (event timestamps, not a register copy) ----------------
  int          edge_n = 0;
  int          last_pulse = -1000;
  int          last_xoff = -1000;
  bit          m_paused = 1'b0;
  int          m_lvl = 0;
  bit          exp_req = 1'b0;
  logic [15:0] exp_val = '0;
  int          exp_xoff_cnt = 0;
  int          exp_xon_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pulse   = -1000;
      last_xoff    = -1000;
      m_paused     = 1'b0;
      m_lvl        = 0;
      exp_req      = 1'b0;
      exp_val      = '0;
      exp_xoff_cnt = 0;
      exp_xon_cnt  = 0;
    end else begin
      bit want, gap_ok, refresh_due;
      edge_n++;
      // level seen here is the one captured on the previous edge; enable is live
      want        = enable && ((m_lvl >= XOFF_T) || (m_paused && (m_lvl > XON_T)));
      gap_ok      = (edge_n - last_pulse) >= MIN_GAP;
      refresh_due = m_paused && ((edge_n - last_xoff) >= REFRESH);
      exp_req     = 1'b0;
      if (gap_ok && m_paused && !want) begin
        exp_req    = 1'b1;
        exp_val    = 16'h0000;
        m_paused   = 1'b0;
        last_pulse = edge_n;
        if (exp_xon_cnt < 65535) exp_xon_cnt++;
      end else if (gap_ok && want && (!m_paused || refresh_due)) begin
        exp_req    = 1'b1;
        exp_val    = 16'hFFFF;
        m_paused   = 1'b1;
        last_pulse = edge_n;
        last_xoff  = edge_n;
        if (exp_xoff_cnt < 65535) exp_xoff_cnt++;
      end
      m_lvl = int'(fifo_level);
    end
  end

  // ---------------- compare process + pulse log ----------------
  int          plog_e[$];
  logic [15:0] plog_v[$];

  always @(negedge clk) begin
    if (chk_on) begin
      chk("pause_req", 32'(pause_req), 32'(exp_req));
      chk("pause_val", 32'(pause_val), 32'(exp_val));
      chk("xoff_active", 32'(xoff_active), 32'(m_paused));
      chk("xoff_cnt", 32'(xoff_cnt), 32'(exp_xoff_cnt));
      chk("xon_cnt", 32'(xon_cnt), 32'(exp_xon_cnt));
    end
    if (pause_req === 1'b1) begin
      plog_e.push_back(edge_n);
      plog_v.push_back(pause_val);
    end
  end

  function automatic int get_e(input int i);
    return (plog_e.size() > i) ? plog_e[i] : -1;
  endfunction

  function automatic int get_v(input int i);
    return (plog_v.size() > i) ? int'(plog_v[i]) : -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  task automatic main_seq();
    int n0, e0, e1, e2;
    // reset state
    rst_n = 1'b0;
    #1;
    chk("rst_pause_req", 32'(pause_req), 0);
    chk("rst_pause_val", 32'(pause_val), 0);
    chk("rst_xoff_active", 32'(xoff_active), 0);
    chk("rst_xoff_cnt", 32'(xoff_cnt), 0);
    chk("rst_xon_cnt", 32'(xon_cnt), 0);
    chk_on = 1'b1;
    step(3);
    rst_n  = 1'b1;
    enable = 1'b1;
    step(5);

    // 1: step to XOFF threshold -> pulse 2 clocks later
    n0 = plog_e.size();
    e0 = edge_n;
    fifo_level = 12'd3072;
    step(4);
    chk("t1_latency", 32'(get_e(n0) - e0), 2);
    chk("t1_val", 32'(get_v(n0)), 32'hFFFF);
    chk("t1_xoff_cnt", 32'(xoff_cnt), 1);

    // 2: hold -> refresh exactly REFRESH clocks later
    step(REFRESH);
    chk("t2_refresh_gap", 32'(get_e(n0 + 1) - get_e(n0)), REFRESH);
    chk("t2_val", 32'(get_v(n0 + 1)), 32'hFFFF);
    chk("t2_xoff_cnt", 32'(xoff_cnt), 2);

    // 3: drain 2000 (no release) then 1024 (release)
    fifo_level = 12'd2000;
    step(40);
    chk("t3_no_pulse_2000", 32'(plog_e.size()), 32'(n0 + 2));
    e0 = edge_n;
    fifo_level = 12'd1024;
    step(5);
    chk("t3_xon_latency", 32'(get_e(n0 + 2) - e0), 2);
    chk("t3_xon_val", 32'(get_v(n0 + 2)), 0);
    chk("t3_xon_cnt", 32'(xon_cnt), 1);

    // 4: XOFF then immediate drain -> XON held off by the gap
    step(20);
    n0 = plog_e.size();
    e1 = edge_n;
    fifo_level = 12'd3072;
    step(3);
    fifo_level = 12'd0;
    step(30);
    chk("t4_xoff_at", 32'(get_e(n0) - e1), 2);
    chk("t4_xon_after_gap", 32'(get_e(n0 + 1) - get_e(n0)), MIN_GAP);
    chk("t4_xon_val", 32'(get_v(n0 + 1)), 0);
    chk("t4_count", 32'(plog_e.size()), 32'(n0 + 2));

    // 5: enable drop in XOFF -> one XON; level 4000 with enable=0 -> nothing
    fifo_level = 12'd3072;
    step(20);
    n0 = plog_e.size();
    e2 = edge_n;
    enable = 1'b0;
    step(3);
    chk("t5_xon_at", 32'(get_e(n0) - e2), 1);
    chk("t5_xon_val", 32'(get_v(n0)), 0);
    fifo_level = 12'd4000;
    step(40);
    chk("t5_no_pulse_disabled", 32'(plog_e.size()), 32'(n0 + 1));
    chk("t5_xoff_active", 32'(xoff_active), 0);

    // 6: re-enable, then async reset during the XOFF pulse
    enable = 1'b1;
    step(1);
    chk("t6_pulse_seen", 32'(pause_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_req", 32'(pause_req), 0);
    chk("t6_async_val", 32'(pause_val), 0);
    chk("t6_async_active", 32'(xoff_active), 0);
    chk("t6_async_xoff_cnt", 32'(xoff_cnt), 0);
    chk("t6_async_xon_cnt", 32'(xon_cnt), 0);
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("t6_after_xoff_cnt", 32'(xoff_cnt), 1);
    chk("t6_after_xon_cnt", 32'(xon_cnt), 0);

    // full-scale level is an ordinary XOFF request
    fifo_level = 12'd0;
    step(30);
    n0 = plog_e.size();
    fifo_level = 12'hFFF;
    step(4);
    chk("max_level_xoff", 32'(get_v(n0)), 32'hFFFF);

    // random phase, biased toward the thresholds and the extremes
    for (int i = 0; i < 70; i++) begin
      int sel;
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: fifo_level = 12'($urandom_range(0, 4095));
        1: fifo_level = 12'd3072;
        2: fifo_level = 12'd3071;
        3: fifo_level = 12'd1024;
        4: fifo_level = 12'd1025;
        5: fifo_level = 12'd0;
        default: fifo_level = 12'hFFF;
      endcase
      if ($urandom_range(0, 7) == 0) enable = ~enable;
      step(int'($urandom_range(1, 40)));
    end
    enable     = 1'b1;
    fifo_level = 12'd3500;
    step(2 * REFRESH + 10);
  endtask

  task automatic sat_seq();
    sat_rst_n = 1'b0;
    step(2);
    sat_rst_n = 1'b1;
    chk("sat_reset", 32'(sat_cnt), 0);
    sat_inc = 1'b1;
    step(10);
    chk("sat_count10", 32'(sat_cnt), 10);
    step(65524);
    chk("sat_fffe", 32'(sat_cnt), 32'hFFFE);
    step(1);
    chk("sat_ffff", 32'(sat_cnt), 32'hFFFF);
    step(5);
    chk("sat_no_wrap", 32'(sat_cnt), 32'hFFFF);
    sat_inc = 1'b0;
  endtask

  initial begin
    fork
      main_seq();
      sat_seq();
    join
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
